// File: rtl/ecc_pkg.sv
// Shared definitions for the SECDED(72,64) memory path: widths, status codes,
// controller states and the check-bit generator used by encoder, decoder and bench.
package ecc_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ECC_WIDTH  = 8;
    localparam int BE_WIDTH   = 8;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_DATA   = 2'b01;
    localparam logic [1:0] ERR_ECC    = 2'b10;
    localparam logic [1:0] ERR_UNCORR = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RD   = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_WR   = 2'd3;

    // Hamming position (1..71) of data bit idx: the idx-th non-power-of-two position.
    function automatic logic [6:0] data_pos(input int idx);
        int         n;
        logic [6:0] pos;
        n   = 0;
        pos = '0;
        for (int p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) pos = 7'(p);
                n++;
            end
        end
        return pos;
    endfunction

    function automatic logic [ECC_WIDTH-1:0] ecc_calc(input logic [DATA_WIDTH-1:0] data);
        logic [6:0] par;
        par = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            if (data[j]) par ^= data_pos(j);
        end
        return {^{data, par}, par};
    endfunction

endpackage

// File: rtl/ecc_dec.sv
// 64-bit SECDED decoder, two register stages: syndrome capture, then correction
// and status classification.
module ecc_dec
    import ecc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic [ECC_WIDTH-1:0]  rd_ecc_i,
    output logic [DATA_WIDTH-1:0] dec_data_o,
    output logic [1:0]            dec_err_o
);

    logic [ECC_WIDTH-1:0]  calc;
    logic [6:0]            syn_d, syn_q;
    logic                  par_d, par_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] fix_d;
    logic [1:0]            err_d;

    assign calc  = ecc_calc(rd_data_i);
    assign syn_d = calc[6:0] ^ rd_ecc_i[6:0];
    assign par_d = ^{rd_data_i, rd_ecc_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            syn_q  <= '0;
            par_q  <= 1'b0;
        end else begin
            data_q <= rd_data_i;
            syn_q  <= syn_d;
            par_q  <= par_d;
        end
    end

    // Odd overall parity means a single flip: a zero or power-of-two syndrome points
    // at a check bit, anything else names the data position to repair.
    always_comb begin
        fix_d = data_q;
        err_d = ERR_NONE;
        if (par_q) begin
            if ((syn_q & (syn_q - 7'd1)) == 7'd0) begin
                err_d = ERR_ECC;
            end else if (syn_q > 7'd71) begin
                err_d = ERR_UNCORR;
            end else begin
                err_d = ERR_DATA;
                for (int j = 0; j < DATA_WIDTH; j++) begin
                    if (syn_q == data_pos(j)) fix_d[j] = ~data_q[j];
                end
            end
        end else if (syn_q != 7'd0) begin
            err_d = ERR_UNCORR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_data_o <= '0;
            dec_err_o  <= ERR_NONE;
        end else begin
            dec_data_o <= fix_d;
            dec_err_o  <= err_d;
        end
    end

endmodule

// File: rtl/ecc_wr_ctrl.sv
// Write-side controller for SECDED-protected RAM: full-word writes are encoded
// directly, partial writes read, correct, merge, re-encode and write back.
module ecc_wr_ctrl
    import ecc_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [BE_WIDTH-1:0]   req_be,
    output logic                  resp_valid,
    output logic [1:0]            resp_err,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic [ECC_WIDTH-1:0]  mem_rd_ecc,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [ECC_WIDTH-1:0]  mem_wr_ecc
);

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BE_WIDTH-1:0]   be,
        input logic [DATA_WIDTH-1:0] old_w
    );
        logic [DATA_WIDTH-1:0] m;
        for (int i = 0; i < BE_WIDTH; i++) begin
            m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return m;
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [ECC_WIDTH-1:0]  wr_ecc_q, wr_ecc_d;
    logic [1:0]            err_q, err_d;
    logic                  zresp_q, zresp_d;
    logic [DATA_WIDTH-1:0] dec_data;
    logic [1:0]            dec_err;
    logic [DATA_WIDTH-1:0] merged;
    logic                  hs;

    ecc_dec u_ecc_dec (
        .clk        (clk),
        .rst_n      (~rst),
        .rd_data_i  (mem_rd_data),
        .rd_ecc_i   (mem_rd_ecc),
        .dec_data_o (dec_data),
        .dec_err_o  (dec_err)
    );

    assign hs     = req_valid & req_ready;
    assign merged = merge_bytes(data_q, be_q, dec_data);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        be_d      = be_q;
        wr_data_d = wr_data_q;
        wr_ecc_d  = wr_ecc_q;
        err_d     = err_q;
        zresp_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    addr_d = req_addr;
                    data_d = req_data;
                    be_d   = req_be;
                    err_d  = ERR_NONE;
                    if (req_be == 8'hFF) begin
                        wr_data_d = req_data;
                        wr_ecc_d  = ecc_calc(req_data);
                        state_d   = ST_WR;
                    end else if (req_be == 8'h00) begin
                        zresp_d = 1'b1;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                cnt_d   = 2'd0;
                state_d = ST_WAIT;
            end
            // One cycle of RAM latency plus two decoder stages.
            ST_WAIT: begin
                if (cnt_q == 2'd2) begin
                    wr_data_d = merged;
                    wr_ecc_d  = ecc_calc(merged);
                    err_d     = dec_err;
                    state_d   = ST_WR;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            wr_data_q <= '0;
            wr_ecc_q  <= '0;
            err_q     <= ERR_NONE;
            zresp_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            be_q      <= be_d;
            wr_data_q <= wr_data_d;
            wr_ecc_q  <= wr_ecc_d;
            err_q     <= err_d;
            zresp_q   <= zresp_d;
        end
    end

    // An uncorrectable old word is left untouched in memory.
    assign req_ready   = (state_q == ST_IDLE) & ~rst;
    assign mem_rd_en   = (state_q == ST_RD);
    assign mem_rd_addr = addr_q;
    assign mem_wr_en   = (state_q == ST_WR) && (err_q != ERR_UNCORR);
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = wr_data_q;
    assign mem_wr_ecc  = wr_ecc_q;
    assign resp_valid  = (state_q == ST_WR) | zresp_q;
    assign resp_err    = (state_q == ST_WR) ? err_q : ERR_NONE;

endmodule
